// File: rtl/axi_wr_slave_mem.sv
// AXI4 write slave backed by a byte-strobed memory: one burst at a time, AW -> W beats -> B.
// awready/wready/bvalid are registered from the next state; dbg_rdata is registered, so a write shows up two edges after its beat.
module axi_wr_slave_mem #(
   parameter int ID_W_WIDTH  = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BRESP_WIDTH = 2,
   parameter int MEM_DEPTH   = 256
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [ID_W_WIDTH-1:0]        awid,
   input  logic [ADDR_WIDTH-1:0]        awaddr,
   input  logic [7:0]                   awlen,
   input  logic [2:0]                   awsize,
   input  logic [1:0]                   awburst,
   input  logic                         awlock,
   input  logic                         wvalid,
   output logic                         wready,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [DATA_WIDTH/8-1:0]      wstrb,
   input  logic                         wlast,
   output logic                         bvalid,
   input  logic                         bready,
   output logic [ID_W_WIDTH-1:0]        bid,
   output logic [BRESP_WIDTH-1:0]       bresp,
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_raddr,
   output logic [DATA_WIDTH-1:0]        dbg_rdata
);

   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int LANE_BITS = $clog2(STRB_W);
   localparam int IDX_W     = $clog2(MEM_DEPTH);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ID_W_WIDTH-1:0] id_q;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [7:0]            cnt_q;
   logic                  err_q;
   logic                  req_err_q;

   logic                  aw_hs, w_hs, b_hs;
   logic                  last_beat;
   logic                  req_err_c;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  in_range;
   logic                  do_write;
   logic [IDX_W-1:0]      mem_idx;
   logic [ADDR_WIDTH-1:0] incr, aligned, wrap_bytes, wrap_base, addr_nxt;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Lock is accepted but has no effect on behaviour.
   logic unused_lock;
   assign unused_lock = awlock;

   assign aw_hs     = awvalid && awready;
   assign w_hs      = wvalid && wready;
   assign b_hs      = bvalid && bready;
   assign last_beat = (cnt_q == len_q);

   assign req_err_c = (awburst == BURST_RSVD)
                   || (awsize > 3'(LANE_BITS))
                   || ((awburst == BURST_WRAP) &&
                       !((awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15)));

   assign word_idx = cur_addr_q >> LANE_BITS;
   assign in_range = (word_idx < ADDR_WIDTH'(MEM_DEPTH));
   assign mem_idx  = word_idx[IDX_W-1:0];
   assign do_write = w_hs && in_range && !req_err_q;

   // Aligning every step is equivalent to aligning only on the first step,
   // since all later addresses are already size-aligned.
   always_comb begin
      incr       = ADDR_WIDTH'(1) << size_q;
      aligned    = cur_addr_q & ~(incr - ADDR_WIDTH'(1));
      wrap_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
      wrap_base  = aligned & ~(wrap_bytes - ADDR_WIDTH'(1));
      addr_nxt   = aligned + incr;
      if (burst_q == BURST_FIXED) begin
         addr_nxt = cur_addr_q;
      end else if ((burst_q == BURST_WRAP) && (addr_nxt == wrap_base + wrap_bytes)) begin
         addr_nxt = wrap_base;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (aw_hs) state_nxt = DATA;
         DATA:    if (w_hs && last_beat) state_nxt = RESP;
         RESP:    if (b_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
      end else begin
         state   <= state_nxt;
         awready <= (state_nxt == IDLE);
         wready  <= (state_nxt == DATA);
         bvalid  <= (state_nxt == RESP);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         id_q       <= '0;
         cur_addr_q <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         req_err_q  <= 1'b0;
      end else if (aw_hs) begin
         id_q       <= awid;
         cur_addr_q <= awaddr;
         len_q      <= awlen;
         size_q     <= awsize;
         burst_q    <= awburst;
         cnt_q      <= '0;
         err_q      <= req_err_c;
         req_err_q  <= req_err_c;
      end else if (w_hs) begin
         cnt_q      <= cnt_q + 8'd1;
         cur_addr_q <= addr_nxt;
         // The beat count ends the burst; a disagreeing wlast only flags it.
         if (!in_range || (wlast != last_beat)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bid   = id_q;
   assign bresp = err_q ? BRESP_WIDTH'(2) : '0;

   always_ff @(posedge aclk) begin
      if (do_write) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem[mem_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dbg_rdata <= '0;
      end else begin
         dbg_rdata <= mem[dbg_raddr];
      end
   end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Bench for axi_wr_slave_mem: table of directed bursts, hand-written reset sequence, and random bursts
// checked against a byte-array memory model computed from the AXI address rules.
module tb_axi_wr_slave_mem;
   localparam int IDW = 4, AW = 32, DW = 32, BW = 2, DEPTH = 256, SW = DW / 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          awvalid = 1'b0, awready;
   logic [IDW-1:0] awid = '0;
   logic [AW-1:0] awaddr = '0;
   logic [7:0]    awlen = '0;
   logic [2:0]    awsize = '0;
   logic [1:0]    awburst = '0;
   logic          awlock = 1'b0;
   logic          wvalid = 1'b0, wready;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic          wlast = 1'b0;
   logic          bvalid, bready = 1'b0;
   logic [IDW-1:0] bid;
   logic [BW-1:0] bresp;
   logic [7:0]    dbg_raddr = '0;
   logic [DW-1:0] dbg_rdata;

   axi_wr_slave_mem #(.ID_W_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .BRESP_WIDTH(BW), .MEM_DEPTH(DEPTH)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          strb_beat;   // -1 all 0xF, -2 random strobes
      logic [3:0]  strb_val;
      int          bad_beat;    // beat whose wlast is inverted, -1 none
      int          bdelay;
      bit          use_fd;
      logic [31:0] fd;
      int          exp;         // expected bresp, -1 take it from the model
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] ref_mem [DEPTH*SW];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_rdy(input int which, input string nm, output bit ok);
      int t = 0;
      while ((((which == 0) ? awready : wready) !== 1'b1) && t < 200) begin
         @(posedge aclk); #1; t++;
      end
      ok = (((which == 0) ? awready : wready) === 1'b1);
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: ready still low after %0d cycles, expected 1", nm, t);
      end
   endtask

   function automatic longint beat_addr(input logic [31:0] start, input int len, input int size,
                                        input int burst, input int i);
      longint nb = longint'(1) << size;
      longint al = (longint'(start) / nb) * nb;
      longint wr, base;
      if (i == 0 || burst == 0) return longint'(start);
      if (burst == 2) begin
         wr   = longint'(len + 1) * nb;
         base = (al / wr) * wr;
         return base + ((al - base + longint'(i) * nb) % wr);
      end
      return al + longint'(i) * nb;
   endfunction

   task automatic sweep(input string tag);
      logic [31:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         dbg_raddr = 8'(i);
         @(posedge aclk); #1;
         w = {ref_mem[i*4+3], ref_mem[i*4+2], ref_mem[i*4+1], ref_mem[i*4]};
         check($sformatf("%s mem[%0d]", tag, i), 64'(dbg_rdata), 64'(w));
      end
   endtask

   task automatic run_burst(input vec_t v, input string tag);
      logic [31:0] d[$];
      logic [3:0]  s[$];
      bit          err, req, ok;
      longint      a, idx;
      logic [1:0]  expb;
      int          n = int'(v.len) + 1;
      for (int i = 0; i < n; i++) begin
         d.push_back(v.use_fd ? v.fd + 32'(i) : $urandom);
         s.push_back(v.strb_beat == -2 ? 4'($urandom) : (i == v.strb_beat ? v.strb_val : 4'hF));
      end
      req = (v.burst == 2'b11) || (v.size > 3'd2) ||
            (v.burst == 2'b10 && !(v.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
      err = req;
      for (int i = 0; i < n; i++) begin
         a   = beat_addr(v.addr, int'(v.len), int'(v.size), int'(v.burst), i);
         idx = a >> 2;
         if (idx >= DEPTH) err = 1;
         else if (!req)
            for (int l = 0; l < SW; l++)
               if (s[i][l]) ref_mem[int'(idx)*4+l] = d[i][l*8 +: 8];
         if (i == v.bad_beat) err = 1;
      end
      expb = (v.exp >= 0) ? 2'(v.exp) : (err ? 2'b10 : 2'b00);

      awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
      awvalid = 1'b1;
      wait_rdy(0, {tag, " aw"}, ok);
      if (!ok) begin awvalid = 1'b0; return; end
      @(posedge aclk); #1;
      awvalid = 1'b0;
      check({tag, " wready_after_aw"}, 64'({wready, awready}), 64'(2'b10));
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1; wdata = d[i]; wstrb = s[i];
         wlast = (i == n - 1) ^ (i == v.bad_beat);
         wait_rdy(1, {tag, " w"}, ok);
         if (!ok) begin wvalid = 1'b0; return; end
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      check({tag, " bvalid_after_last"}, 64'({bvalid, wready}), 64'(2'b10));
      for (int k = 0; k < v.bdelay; k++) begin
         @(posedge aclk); #1;
         check({tag, " b_hold"}, 64'({bvalid, awready, bid, bresp}), 64'({1'b1, 1'b0, v.id, expb}));
      end
      check({tag, " bid_bresp"}, 64'({bid, bresp}), 64'({v.id, expb}));
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      check({tag, " after_b"}, 64'({bvalid, awready}), 64'(2'b01));
      sweep(tag);
   endtask

   vec_t tbl [14];
   vec_t v;

   initial begin
      tbl[0]  = '{4'd1,  32'h10,  8'd0,  3'd2, 2'd1, -1, 4'h0, -1, 0, 1'b1, 32'hA5A51234, 0};
      tbl[1]  = '{4'd2,  32'h00,  8'd3,  3'd2, 2'd1,  2, 4'h3, -1, 1, 1'b0, 32'h0, 0};
      tbl[2]  = '{4'd3,  32'h08,  8'd3,  3'd2, 2'd2, -1, 4'h0, -1, 0, 1'b0, 32'h0, 0};
      tbl[3]  = '{4'd4,  32'h20,  8'd3,  3'd2, 2'd0, -1, 4'h0, -1, 0, 1'b0, 32'h0, 0};
      tbl[4]  = '{4'd5,  32'h30,  8'd1,  3'd2, 2'd3, -1, 4'h0, -1, 0, 1'b0, 32'h0, 2};
      tbl[5]  = '{4'd6,  32'h30,  8'd1,  3'd3, 2'd1, -1, 4'h0, -1, 0, 1'b0, 32'h0, 2};
      tbl[6]  = '{4'd7,  32'h400, 8'd0,  3'd2, 2'd1, -1, 4'h0, -1, 0, 1'b0, 32'h0, 2};
      tbl[7]  = '{4'd8,  32'h40,  8'd3,  3'd2, 2'd1, -1, 4'h0,  1, 5, 1'b0, 32'h0, 2};
      tbl[8]  = '{4'd9,  32'h48,  8'd2,  3'd2, 2'd2, -1, 4'h0, -1, 0, 1'b0, 32'h0, 2};
      tbl[9]  = '{4'd10, 32'h3F8, 8'd3,  3'd2, 2'd1, -1, 4'h0, -1, 0, 1'b0, 32'h0, 2};
      tbl[10] = '{4'd11, 32'h51,  8'd5,  3'd0, 2'd1, -1, 4'h0, -1, 0, 1'b0, 32'h0, 0};
      tbl[11] = '{4'd12, 32'h6C,  8'd7,  3'd2, 2'd2, -1, 4'h0, -1, 2, 1'b0, 32'h0, 0};
      tbl[12] = '{4'd15, 32'h7E,  8'd2,  3'd1, 2'd0, -1, 4'h0, -1, 0, 1'b0, 32'h0, 0};
      tbl[13] = '{4'd14, 32'hA0,  8'd15, 3'd2, 2'd1, -2, 4'h0, -1, 3, 1'b0, 32'h0, 0};

      #12;
      check("reset_outputs", 64'({awready, wready, bvalid, bid, bresp}), 64'(0));
      check("reset_dbg_rdata", 64'(dbg_rdata), 64'(0));
      @(posedge aclk); #1;
      aresetn = 1'b1;
      check("awready_at_release", 64'(awready), 64'(0));
      @(posedge aclk); #1;
      check("awready_after_release", 64'(awready), 64'(1));

      // Fill the whole memory so every later sweep has defined contents.
      v = '{4'd0, 32'h0, 8'd255, 3'd2, 2'd1, -1, 4'h0, -1, 0, 1'b0, 32'h0, 0};
      run_burst(v, "init");

      for (int t = 0; t < 14; t++) begin
         run_burst(tbl[t], $sformatf("vec%0d", t));
         if (t == 0) begin
            dbg_raddr = 8'd4;
            @(posedge aclk); #1;
            check("single_incr_word4", 64'(dbg_rdata), 64'(32'hA5A51234));
         end
      end

      // Reset in the middle of an 8-beat burst, after two beats.
      awid = 4'd3; awaddr = 32'h0; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
      awvalid = 1'b1;
      begin
         bit ok;
         wait_rdy(0, "rst_seq aw", ok);
         @(posedge aclk); #1;
         awvalid = 1'b0;
         for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 32'h1111_0000 * 32'(i + 1) + 32'(i); wstrb = 4'hF; wlast = 1'b0;
            wait_rdy(1, "rst_seq w", ok);
            @(posedge aclk); #1;
            for (int l = 0; l < SW; l++) ref_mem[i*4+l] = wdata[l*8 +: 8];
         end
      end
      aresetn = 1'b0; wvalid = 1'b0;
      #2;
      check("midburst_reset_outputs", 64'({awready, wready, bvalid, bid, bresp}), 64'(0));
      check("midburst_reset_dbg", 64'(dbg_rdata), 64'(0));
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      check("post_reset_idle", 64'({awready, wready, bvalid}), 64'(3'b100));
      sweep("post_reset");
      v = '{4'd9, 32'h20, 8'd3, 3'd2, 2'd1, -1, 4'h0, -1, 0, 1'b0, 32'h0, 0};
      run_burst(v, "after_reset");

      for (int r = 0; r < 25; r++) begin
         v.id       = 4'($urandom);
         v.burst    = 2'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : 3);
         v.size     = 3'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
         if (v.burst == 2'd2 && $urandom_range(0, 4) != 0)
            v.len = 8'((2 << $urandom_range(0, 3)) - 1);
         else
            v.len = 8'($urandom_range(0, 15));
         v.addr     = 32'($urandom_range(0, 'h43F));
         v.strb_beat = -2;
         v.strb_val = 4'h0;
         v.bad_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(v.len))) : -1;
         v.bdelay   = int'($urandom_range(0, 3));
         v.use_fd   = 1'b0;
         v.fd       = 32'h0;
         v.exp      = -1;
         run_burst(v, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
